matrix_result_streamer: RTL
===========================

MATRIX_RESULT_STREAMER -- requirements
Module: matrix_result_streamer

Interface
REQ-001 Parameter NUM_ROW, default 2, row count of the result matrix; legal range 1..16.
REQ-002 Parameter NUM_COL, default 2, column count of the result matrix; legal range 1..16.
REQ-003 clk  input  1  clock; all state on rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 mat_in  input  32*NUM_ROW*NUM_COL  packed IEEE-754 single result matrix, row-major; element (0,0) in MSBs.
REQ-006 mat_ready  input  1  level; mat_in valid and stable while high.
REQ-007 mat_ack  output  1  one-cycle pulse; matrix captured and upstream may release it.
REQ-008 elem_data  output  32  current streamed element.
REQ-009 elem_valid  output  1  elem_data/elem_row/elem_col/elem_last valid.
REQ-010 elem_ready  input  1  downstream accepts the element when high together with elem_valid.
REQ-011 elem_row  output  max(1,$clog2(NUM_ROW))  row index of the current element.
REQ-012 elem_col  output  max(1,$clog2(NUM_COL))  column index of the current element.
REQ-013 elem_last  output  1  high with the final element (NUM_ROW-1,NUM_COL-1).

Function
REQ-014 FSM states IDLE, ACK, STREAM; encoding from the shared package.
REQ-015 IDLE: on mat_ready=1, capture mat_in into an internal buffer, clear row/col counters, go ACK.
REQ-016 ACK: mat_ack=1 for exactly this one cycle, elem_valid=0, go STREAM unconditionally.
REQ-017 STREAM: elem_valid=1; elem_data = buffer element (elem_row,elem_col); a transfer occurs on the cycle elem_valid&elem_ready.
REQ-018 On transfer, col increments; at col=NUM_COL-1, col wraps to 0 and row increments.
REQ-019 On transfer with elem_last=1, go IDLE; elem_valid is 0 the following cycle.
REQ-020 With elem_ready=0, all element outputs hold their values (no change while stalled).
REQ-021 mat_ready and mat_in are ignored in ACK and STREAM; buffer changes only on IDLE capture.
REQ-022 mat_ready must drop within one cycle of mat_ack; mat_ready still high in IDLE causes a new capture.
REQ-023 Latency: mat_ready sampled high in IDLE -> mat_ack 1 cycle later -> first elem_valid 2 cycles later.
REQ-024 Throughput: one element per cycle with elem_ready held high; NUM_ROW*NUM_COL transfers per matrix.
REQ-025 NUM_ROW=NUM_COL=1: the single element has elem_last=1 and elem_row=elem_col=0.

Reset
REQ-026 rst low, at any time, forces IDLE, mat_ack=0, elem_valid=0, elem_last=0, elem_data=0, elem_row=0, elem_col=0 and clears the buffer.
REQ-027 A reset during STREAM abandons the remaining elements; after release no element is emitted until a new capture.

Configuration
REQ-028 Macro MATRIX_RESULT_STREAMER_SPECIAL_FLAG_EN: when defined, adds output elem_special (1 bit, valid with elem_valid).
REQ-029 elem_special=1 iff elem_data exponent is 8'hFF (Inf/NaN); elem_special=0 on reset.
REQ-030 Without the macro, the port and its logic are absent; all other behaviour is identical.

Structure
REQ-031 The shared package holds ELEMENT_LENGTH=32, the FSM state typedef, and the element-extract function (row, col, NUM_COL -> bit offset).
REQ-032 Single module, no sub-modules; the special-value detect is inline combinational logic under the macro.

Verification
REQ-033 2x2, mat_in={3F800000,40000000,40400000,40800000}, elem_ready=1 -> one mat_ack pulse; elements 1.0,2.0,3.0,4.0 on 4 consecutive cycles with (row,col) 00,01,10,11; elem_last only on 4.0.
REQ-034 Same matrix, elem_ready toggled 1,0,0,1,0,1,1 -> every element held while stalled; exactly 4 transfers; order unchanged.
REQ-035 Change mat_in and pulse mat_ready during STREAM -> streamed values remain the captured ones; no extra mat_ack.
REQ-036 rst low after 2nd transfer -> elem_valid=0 immediately; after release and a new mat_ready, stream restarts at (0,0).
REQ-037 3x1 and 1x1 configs -> correct index wrap; elem_last on element (2,0) and (0,0) respectively.
REQ-038 With the macro defined, element 7FC00000 -> elem_special=1; element 3F800000 -> elem_special=0.

Source files
------------

// File: rtl/matrix_result_streamer_pkg.sv
// Shared types and helpers for matrix_result_streamer: element width, FSM states,
// and the row/column to bit-offset mapping of the packed row-major matrix.
package matrix_result_streamer_pkg;

    localparam int unsigned ELEMENT_LENGTH = 32;

    typedef enum logic [1:0] {
        StIdle   = 2'd0,
        StAck    = 2'd1,
        StStream = 2'd2
    } state_e;

    // Offset measured from the MSB end: element (0,0) sits in the top bits.
    function automatic int unsigned elem_offset(input int unsigned row,
                                                input int unsigned col,
                                                input int unsigned num_col);
        return (row * num_col + col) * ELEMENT_LENGTH;
    endfunction

endpackage

// File: rtl/matrix_result_streamer.sv
// Captures a packed result matrix and streams it out one element per handshake, row-major.
// Optional elem_special output (Inf/NaN flag) when MATRIX_RESULT_STREAMER_SPECIAL_FLAG_EN is defined.
module matrix_result_streamer
    import matrix_result_streamer_pkg::*;
#(
    parameter int unsigned NUM_ROW = 2,
    parameter int unsigned NUM_COL = 2,
    localparam int unsigned ROW_W = (NUM_ROW > 1) ? $clog2(NUM_ROW) : 1,
    localparam int unsigned COL_W = (NUM_COL > 1) ? $clog2(NUM_COL) : 1,
    localparam int unsigned MAT_W = ELEMENT_LENGTH * NUM_ROW * NUM_COL
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [MAT_W-1:0]          mat_in,
    input  logic                      mat_ready,
    output logic                      mat_ack,
    output logic [ELEMENT_LENGTH-1:0] elem_data,
    output logic                      elem_valid,
    input  logic                      elem_ready,
    output logic [ROW_W-1:0]          elem_row,
    output logic [COL_W-1:0]          elem_col,
    output logic                      elem_last
`ifdef MATRIX_RESULT_STREAMER_SPECIAL_FLAG_EN
    ,
    output logic                      elem_special
`endif
);

    localparam logic [ROW_W-1:0] ROW_MAX = ROW_W'(NUM_ROW - 1);
    localparam logic [COL_W-1:0] COL_MAX = COL_W'(NUM_COL - 1);

    state_e           state_q, state_d;
    logic [MAT_W-1:0] buf_q, buf_d;
    logic [ROW_W-1:0] row_q, row_d;
    logic [COL_W-1:0] col_q, col_d;
    logic             at_last;
    logic [MAT_W-1:0] buf_shifted;

    assign at_last = (row_q == ROW_MAX) && (col_q == COL_MAX);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        row_d   = row_q;
        col_d   = col_q;
        case (state_q)
            StIdle: begin
                if (mat_ready) begin
                    buf_d   = mat_in;
                    row_d   = '0;
                    col_d   = '0;
                    state_d = StAck;
                end
            end
            StAck: begin
                state_d = StStream;
            end
            StStream: begin
                if (elem_ready) begin
                    if (at_last) begin
                        row_d   = '0;
                        col_d   = '0;
                        state_d = StIdle;
                    end else if (col_q == COL_MAX) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= StIdle;
            buf_q   <= '0;
            row_q   <= '0;
            col_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            row_q   <= row_d;
            col_q   <= col_d;
        end
    end

    // Shift the selected element up to the MSBs rather than using a variable part-select.
    assign buf_shifted = buf_q << elem_offset(32'(row_q), 32'(col_q), NUM_COL);

    assign mat_ack    = (state_q == StAck);
    assign elem_valid = (state_q == StStream);
    assign elem_last  = elem_valid && at_last;
    assign elem_row   = row_q;
    assign elem_col   = col_q;
    assign elem_data  = buf_shifted[MAT_W-1 -: ELEMENT_LENGTH];

`ifdef MATRIX_RESULT_STREAMER_SPECIAL_FLAG_EN
    assign elem_special = (elem_data[30:23] == 8'hFF);
`endif

endmodule
